pc_sequencer: RTL and testbench

Program-counter sequencer for the single-issue MIPS core. Holds the PC, fetches each instruction over a req/ack handshake to instruction memory, then resolves the next PC from the instruction decoder's `PC_src` and `Branch_type` outputs plus ALU flags. It sits between instruction memory and the decoder/ALU, consuming the control encodings the decoder produces.

---
 rtl/cpu_ctrl_pkg.sv | 30 +++
 rtl/branch_cond.sv | 23 ++
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 tb/tb_pc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Control encodings shared by the MIPS front end (decoder, ALU, PC sequencer).
// The TRAP state is present only when PC_ALIGN_CHECK_EN is defined.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_NORM = 2'b00,
        PC_BR   = 2'b01,
        PC_JR   = 2'b10,
        PC_J    = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BR_BLE  = 2'b00,
        BR_BLTZ = 2'b01,
        BR_BEQ  = 2'b10,
        BR_BNE  = 2'b11
    } branch_type_e;

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ISSUE, ST_TRAP} pc_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ISSUE} pc_state_e;
`endif

    // Branch immediates count words; scale to bytes with sign extension.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution: maps the decoder's branch type plus ALU zero/sign flags
// to a taken decision. Purely combinational.
module branch_cond
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] branch_type,
    input  logic       zero,
    input  logic       sign,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_type_e'(branch_type))
            BR_BLE:  taken = zero | sign;
            BR_BLTZ: taken = sign;
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches over a req/ack handshake, issues, then
// resolves the next PC. Optional misaligned-target trap via PC_ALIGN_CHECK_EN.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    input  logic        stall_i,
    input  logic [1:0]  PC_src_i,
    input  logic [1:0]  Branch_type_i,
    input  logic        zero_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs_data_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] jaddr_i,
    output logic        flush_o,
    output logic [31:0] retired_cnt_o,
    output logic        misalign_o
);

    pc_state_e   state_reg;
    logic [31:0] pc_reg;
    logic [31:0] retired_reg;
    logic        req_reg;
    logic        valid_reg;
    logic        flush_reg;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] target;
    logic        redirect;
    logic        br_taken;
    logic        trap_now;
    logic        unused_bits;

    assign pc_plus4 = pc_reg + 32'd4;

    branch_cond u_branch_cond (
        .branch_type (Branch_type_i),
        .zero        (zero_i),
        .sign        (alu_result_i[31]),
        .taken       (br_taken)
    );

    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        case (pc_src_e'(PC_src_i))
            PC_BR: begin
                if (br_taken) begin
                    next_pc  = pc_plus4 + branch_offset(imm_i);
                    redirect = 1'b1;
                end
            end
            PC_JR: begin
                next_pc  = rs_data_i;
                redirect = 1'b1;
            end
            PC_J: begin
                next_pc  = {pc_plus4[31:28], jaddr_i, 2'b00};
                redirect = 1'b1;
            end
            default: begin
                next_pc  = pc_plus4;
                redirect = 1'b0;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_reg;
    assign target      = next_pc;
    assign trap_now    = redirect & (|next_pc[1:0]);
    assign misalign_o  = misalign_reg;
    assign unused_bits = ^alu_result_i[30:0];
`else
    // Without the check, low address bits are simply dropped.
    assign target      = {next_pc[31:2], 2'b00};
    assign trap_now    = 1'b0;
    assign misalign_o  = 1'b0;
    assign unused_bits = ^{alu_result_i[30:0], next_pc[1:0]};
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            retired_reg  <= 32'd0;
            req_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            flush_reg    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            flush_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_FETCH;
                    req_reg   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack_i) begin
                        state_reg <= ST_ISSUE;
                        req_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!stall_i) begin
                        valid_reg <= 1'b0;
                        if (trap_now) begin
`ifdef PC_ALIGN_CHECK_EN
                            state_reg    <= ST_TRAP;
                            misalign_reg <= 1'b1;
`endif
                        end else begin
                            state_reg   <= ST_FETCH;
                            req_reg     <= 1'b1;
                            pc_reg      <= target;
                            flush_reg   <= redirect;
                            retired_reg <= retired_reg + 32'd1;
                        end
                    end
                end
                // TRAP is left only through reset.
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign imem_req_o    = req_reg;
    assign instr_valid_o = valid_reg;
    assign flush_o       = flush_reg;
    assign pc_o          = pc_reg;
    assign pc_plus4_o    = pc_plus4;
    assign retired_cnt_o = retired_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed instructions, a transaction
// model of the PC rules, and a per-cycle compare process.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_i;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;
    logic        stall_i;
    logic [1:0]  PC_src_i;
    logic [1:0]  Branch_type_i;
    logic        zero_i;
    logic [31:0] alu_result_i;
    logic [31:0] rs_data_i;
    logic [15:0] imm_i;
    logic [25:0] jaddr_i;
    logic        flush_o;
    logic [31:0] retired_cnt_o;
    logic        misalign_o;

    localparam logic [1:0] S_NORM = 2'b00, S_BR = 2'b01, S_JR = 2'b10, S_J = 2'b11;
    localparam logic [1:0] T_BLE = 2'b00, T_BLTZ = 2'b01, T_BEQ = 2'b10, T_BNE = 2'b11;

    pc_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_ack_i    (imem_ack_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_valid_o (instr_valid_o),
        .stall_i       (stall_i),
        .PC_src_i      (PC_src_i),
        .Branch_type_i (Branch_type_i),
        .zero_i        (zero_i),
        .alu_result_i  (alu_result_i),
        .rs_data_i     (rs_data_i),
        .imm_i         (imm_i),
        .jaddr_i       (jaddr_i),
        .flush_o       (flush_o),
        .retired_cnt_o (retired_cnt_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          neg_cnt  = 0;
    int          flush_neg = -1;
    int          n_instr  = 0;
    bit          chk_en   = 1'b0;
    logic [31:0] m_pc     = 32'd0;
    logic [31:0] m_cnt    = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Next PC from the architectural rules; targets are word-aligned by masking.
    function automatic logic [31:0] model_next(
        input  logic [31:0] pc,
        input  logic [1:0]  src,
        input  logic [1:0]  bt,
        input  logic        z,
        input  logic [31:0] alu,
        input  logic [31:0] rs,
        input  logic [15:0] imm,
        input  logic [25:0] ja,
        output logic        redir
    );
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        taken;
        seq = pc + 32'd4;
        if (bt == T_BLE)       taken = z || alu[31];
        else if (bt == T_BLTZ) taken = alu[31];
        else if (bt == T_BEQ)  taken = z;
        else                   taken = !z;
        redir = (src == S_JR) || (src == S_J) || (src == S_BR && taken);
        if (src == S_BR && taken) tgt = seq + 32'($signed(imm)) * 32'd4;
        else if (src == S_JR)     tgt = rs;
        else if (src == S_J)      tgt = (seq & 32'hF000_0000) | ({6'b0, ja} << 2);
        else                      tgt = seq;
        return tgt & ~32'd3;
    endfunction

    task automatic drive_junk();
        PC_src_i      = 2'($urandom_range(0, 3));
        Branch_type_i = 2'($urandom_range(0, 3));
        zero_i        = 1'($urandom_range(0, 1));
        alu_result_i  = $urandom;
        rs_data_i     = $urandom;
        imm_i         = 16'($urandom);
        jaddr_i       = 26'($urandom);
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input int ack_wait, input int stall_n,
                             input logic [1:0] src, input logic [1:0] bt, input logic z,
                             input logic [31:0] alu, input logic [31:0] rs,
                             input logic [15:0] imm, input logic [25:0] ja);
        int          guard;
        logic [31:0] npc;
        logic        redir;
        guard = 0;
        while (!imem_req_o && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("fetch_req", 32'(imem_req_o), 32'd1);
        drive_junk();
        imem_ack_i = 1'b0;
        repeat (ack_wait) begin
            @(posedge clk); #1;
        end
        imem_ack_i = 1'b1;
        @(posedge clk); #1;
        imem_ack_i = 1'b0;
        check("issue_valid", 32'(instr_valid_o), 32'd1);
        repeat (stall_n) begin
            stall_i = 1'b1;
            drive_junk();
            imem_ack_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        stall_i       = 1'b0;
        imem_ack_i    = 1'b0;
        PC_src_i      = src;
        Branch_type_i = bt;
        zero_i        = z;
        alu_result_i  = alu;
        rs_data_i     = rs;
        imm_i         = imm;
        jaddr_i       = ja;
        npc = model_next(m_pc, src, bt, z, alu, rs, imm, ja, redir);
        @(posedge clk);
        $display("instr %0d: src=%0d bt=%0d pc %h -> %h redirect=%0d",
                 n_instr, src, bt, m_pc, npc, redir);
        n_instr++;
        m_pc      = npc;
        m_cnt     = m_cnt + 32'd1;
        flush_neg = redir ? neg_cnt + 1 : -1;
        #1;
        drive_junk();
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (chk_en) begin
                check("pc", pc_o, m_pc);
                check("pc_plus4", pc_plus4_o, m_pc + 32'd4);
                check("retired", retired_cnt_o, m_cnt);
                check("flush", 32'(flush_o), 32'(neg_cnt == flush_neg));
                check("misalign", 32'(misalign_o), 32'd0);
                check("req_valid_excl", 32'(imem_req_o & instr_valid_o), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        imem_ack_i = 1'b0;
        stall_i = 1'b0;
        drive_junk();
        #2 rst_i = 1'b0;
        #1;
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_cnt", retired_cnt_o, 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i  = 1'b1;
        chk_en = 1'b1;

        // Sequential flow 0, 4, 8.
        for (int i = 0; i < 3; i++) run_instr(0, 0, S_NORM, T_BEQ, 1'b1, 32'h0, 32'h0, 16'h0, 26'h0);
        check("seq_cnt", retired_cnt_o, 32'd3);
        check("seq_pc", pc_o, 32'h0000_000C);
        for (int i = 0; i < 5; i++) run_instr(1, 0, S_NORM, T_BNE, 1'b0, 32'h0, 32'h0, 16'h0, 26'h0);
        check("at_20", pc_o, 32'h0000_0020);

        // beq back onto itself, then bne not taken.
        run_instr(0, 0, S_BR, T_BEQ, 1'b1, 32'h0, 32'h0, 16'hFFFF, 26'h0);
        check("beq_taken", pc_o, 32'h0000_0020);
        run_instr(0, 0, S_BR, T_BNE, 1'b1, 32'h0, 32'h0, 16'hFFFF, 26'h0);
        check("bne_not", pc_o, 32'h0000_0024);

        // ble / bltz sweep with a +4 word offset.
        run_instr(0, 0, S_BR, T_BLE,  1'b0, 32'h8000_0000, 32'h0, 16'h0004, 26'h0);
        check("ble_neg", pc_o, 32'h0000_0038);
        run_instr(0, 0, S_BR, T_BLTZ, 1'b0, 32'h8000_0000, 32'h0, 16'h0004, 26'h0);
        check("bltz_neg", pc_o, 32'h0000_004C);
        run_instr(0, 0, S_BR, T_BLE,  1'b1, 32'h0, 32'h0, 16'h0004, 26'h0);
        check("ble_zero", pc_o, 32'h0000_0060);
        run_instr(0, 0, S_BR, T_BLTZ, 1'b1, 32'h0, 32'h0, 16'h0004, 26'h0);
        check("bltz_zero", pc_o, 32'h0000_0064);
        run_instr(0, 0, S_BR, T_BLE,  1'b0, 32'h1, 32'h0, 16'h0004, 26'h0);
        check("ble_pos", pc_o, 32'h0000_0068);
        run_instr(0, 0, S_BR, T_BLTZ, 1'b0, 32'h1, 32'h0, 16'h0004, 26'h0);
        check("bltz_pos", pc_o, 32'h0000_006C);

        // Jumps.
        run_instr(0, 0, S_JR, T_BEQ, 1'b0, 32'h0, 32'hF000_0000, 16'h0, 26'h0);
        check("jr_high", pc_o, 32'hF000_0000);
        run_instr(0, 0, S_J, T_BEQ, 1'b0, 32'h0, 32'h0, 16'h0, 26'h10);
        check("j_region", pc_o, 32'hF000_0040);
        run_instr(0, 0, S_JR, T_BEQ, 1'b0, 32'h0, 32'h100, 16'h0, 26'h0);
        check("jr_100", pc_o, 32'h0000_0100);

        // Slow ack and stalled taken branch: one redirect, one retire.
        run_instr(3, 2, S_BR, T_BEQ, 1'b1, 32'h0, 32'h0, 16'h0010, 26'h0);
        check("stall_br_pc", pc_o, 32'h0000_0144);
        check("stall_br_cnt", retired_cnt_o, 32'd20);

        // Asynchronous reset mid-fetch with an ack pending.
        chk_en = 1'b0;
        imem_ack_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req_o), 32'd0);
        check("midrst_pc", pc_o, 32'h0);
        check("midrst_cnt", retired_cnt_o, 32'd0);
        check("midrst_flush", 32'(flush_o), 32'd0);
        check("midrst_valid", 32'(instr_valid_o), 32'd0);
        @(posedge clk); #1;
        check("midrst_hold", 32'(imem_req_o), 32'd0);
        imem_ack_i = 1'b0;
        rst_i      = 1'b1;
        m_pc       = 32'h0;
        m_cnt      = 32'h0;
        flush_neg  = -1;
        chk_en     = 1'b1;
        run_instr(0, 0, S_NORM, T_BEQ, 1'b0, 32'h0, 32'h0, 16'h0, 26'h0);
        check("restart_pc", pc_o, 32'h0000_0004);

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned jr traps and stays put.
        chk_en = 1'b0;
        imem_ack_i = 1'b1;
        @(posedge clk); #1;
        imem_ack_i    = 1'b0;
        stall_i       = 1'b0;
        PC_src_i      = S_JR;
        rs_data_i     = 32'h0000_0102;
        @(posedge clk); #1;
        $display("instr %0d: jr 0x102 at pc 0x4 -> trap", n_instr);
        check("trap_misalign", 32'(misalign_o), 32'd1);
        check("trap_req", 32'(imem_req_o), 32'd0);
        check("trap_valid", 32'(instr_valid_o), 32'd0);
        check("trap_pc", pc_o, 32'h0000_0004);
        imem_ack_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("trap_req_hold", 32'(imem_req_o), 32'd0);
        check("trap_cnt", retired_cnt_o, 32'd1);
        check("trap_sticky", 32'(misalign_o), 32'd1);
`else
        // Misaligned jr target has its low bits dropped.
        run_instr(0, 0, S_JR, T_BEQ, 1'b0, 32'h0, 32'h0000_0102, 16'h0, 26'h0);
        check("jr_align", pc_o, 32'h0000_0100);
        check("jr_align_cnt", retired_cnt_o, 32'd2);
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
